// File: rtl/retro16_pkg.sv
// Shared definitions for the retro16 register-file write path.
// Contents:
//   REG_ZERO / REG_PC   - architectural register indices with fixed meaning
//   REQ_PC/ALU/LD       - bit positions of each writeback requester in the
//                         request/grant vectors
//   arb_state_e         - write arbiter FSM states
package retro16_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_PC   = 6;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_PC  = 0;
  localparam int unsigned REQ_ALU = 1;
  localparam int unsigned REQ_LD  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    COMMIT
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_pick.sv
// Combinational winner selection for the register-file write port.
// Ports:
//   valid  in  [NUM_REQ] request valids, indexed by REQ_*
//   excl   in  [NUM_REQ] requesters barred from this pick
//   rr_ld  in  1         round-robin pointer: 1 = prefer load over ALU
//   any    out 1         some eligible request exists
//   grant  out [NUM_REQ] one-hot winner (all zero when any = 0)
module regfile_wr_pick
  import retro16_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [NUM_REQ-1:0] excl,
  input  logic               rr_ld,
  output logic               any,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] elig;

  always_comb begin
    elig  = valid & ~excl;
    grant = '0;
    if (elig[REQ_PC]) begin
      // PC always wins; it is never back-to-back so ALU/load cannot starve.
      grant[REQ_PC] = 1'b1;
    end else if (elig[REQ_ALU] && elig[REQ_LD]) begin
      if (rr_ld) begin
        grant[REQ_LD] = 1'b1;
      end else begin
        grant[REQ_ALU] = 1'b1;
      end
    end else if (elig[REQ_ALU]) begin
      grant[REQ_ALU] = 1'b1;
    end else if (elig[REQ_LD]) begin
      grant[REQ_LD] = 1'b1;
    end
  end

  assign any = |elig;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between PC update, ALU
// writeback and load writeback, and drives the two-step (SETUP, COMMIT)
// write protocol.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pc_valid/pc_data           PC update request (target fixed to PC_REG)
//   alu_valid/alu_num/alu_data ALU writeback request
//   ld_valid/ld_num/ld_data    load writeback request
//   pc_ready/alu_ready/ld_ready one-cycle pulse in the commit cycle
//   rf_write_num/data/en       register file write port
//   wr_pending/wr_pending_num  in-flight write indication for hazard logic
module regfile_write_arbiter
  import retro16_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned PC_REG = REG_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_valid,
  input  logic [DATA_W-1:0] pc_data,
  output logic              pc_ready,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_num,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [REG_W-1:0]  ld_num,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [REG_W-1:0]  rf_write_num,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              wr_pending,
  output logic [REG_W-1:0]  wr_pending_num
);

  localparam logic [REG_W-1:0] PcNum = REG_W'(PC_REG);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] win_q;   // grant locked from SETUP through COMMIT
  logic               rr_ld_q;

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] excl_vec;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic [REG_W-1:0]   pick_num;
  logic [DATA_W-1:0]  pick_data;

  always_comb begin
    valid_vec          = '0;
    valid_vec[REQ_PC]  = pc_valid;
    valid_vec[REQ_ALU] = alu_valid;
    valid_vec[REQ_LD]  = ld_valid;
  end

  // The committing winner still holds valid during its ready cycle, so it
  // must be kept out of the pick made at the end of COMMIT.
  assign excl_vec = (state_q == COMMIT) ? win_q : '0;

  regfile_wr_pick u_pick (
    .valid (valid_vec),
    .excl  (excl_vec),
    .rr_ld (rr_ld_q),
    .any   (pick_any),
    .grant (pick_grant)
  );

  always_comb begin
    pick_num  = PcNum;
    pick_data = pc_data;
    if (pick_grant[REQ_ALU]) begin
      pick_num  = alu_num;
      pick_data = alu_data;
    end else if (pick_grant[REQ_LD]) begin
      pick_num  = ld_num;
      pick_data = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      win_q         <= '0;
      rr_ld_q       <= 1'b0;
      rf_write_num  <= '0;
      rf_write_data <= '0;
      rf_write_en   <= 1'b0;
      wr_pending    <= 1'b0;
      pc_ready      <= 1'b0;
      alu_ready     <= 1'b0;
      ld_ready      <= 1'b0;
    end else begin
      rf_write_en <= 1'b0;
      pc_ready    <= 1'b0;
      alu_ready   <= 1'b0;
      ld_ready    <= 1'b0;
      unique case (state_q)
        IDLE, COMMIT: begin
          if (pick_any) begin
            state_q       <= SETUP;
            win_q         <= pick_grant;
            rf_write_num  <= pick_num;
            rf_write_data <= pick_data;
            wr_pending    <= 1'b1;
            // Prefer the other member of the ALU/load pair next time.
            if (pick_grant[REQ_ALU]) begin
              rr_ld_q <= 1'b1;
            end else if (pick_grant[REQ_LD]) begin
              rr_ld_q <= 1'b0;
            end
          end else begin
            state_q    <= IDLE;
            win_q      <= '0;
            wr_pending <= 1'b0;
          end
        end
        SETUP: begin
          state_q     <= COMMIT;
          rf_write_en <= 1'b1;
          pc_ready    <= win_q[REQ_PC];
          alu_ready   <= win_q[REQ_ALU];
          ld_ready    <= win_q[REQ_LD];
        end
        default: begin
          state_q    <= IDLE;
          wr_pending <= 1'b0;
        end
      endcase
    end
  end

  assign wr_pending_num = rf_write_num;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_valid = 1'b0;
  logic [15:0] pc_data = '0;
  logic        pc_ready;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_num = '0;
  logic [15:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_num = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic [2:0]  rf_write_num;
  logic [15:0] rf_write_data;
  logic        rf_write_en;
  logic        wr_pending;
  logic [2:0]  wr_pending_num;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_valid       (pc_valid),
    .pc_data        (pc_data),
    .pc_ready       (pc_ready),
    .alu_valid      (alu_valid),
    .alu_num        (alu_num),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_valid       (ld_valid),
    .ld_num         (ld_num),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .rf_write_num   (rf_write_num),
    .rf_write_data  (rf_write_data),
    .rf_write_en    (rf_write_en),
    .wr_pending     (wr_pending),
    .wr_pending_num (wr_pending_num)
  );

  // Register file attached to the write port; r0 is hardwired to zero.
  logic [15:0] rf_mem [8] = '{default: 16'h0};
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_write_num] <= (rf_write_num == 3'd0) ? 16'h0 : rf_write_data;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: a write occupies a two-cycle slot. slot_left = 2 in the
  // first (setup) cycle, 1 in the commit cycle, 0 when the port is free.
  int          slot_left = 0;
  int          cur = 0;          // 0 = PC, 1 = ALU, 2 = load
  logic [2:0]  cur_num = '0;
  logic [15:0] cur_data = '0;
  bit          prefer_ld = 1'b0;
  logic [15:0] exp_rf [8] = '{default: 16'h0};

  // Bench-side requester state for the random phase.
  bit          req_v [3];
  logic [2:0]  req_num [3];
  logic [15:0] req_data [3];
  bit          done [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    slot_left = 0;
    cur       = 0;
    cur_num   = '0;
    cur_data  = '0;
    prefer_ld = 1'b0;
  endtask

  // Applied at each rising edge with the inputs the DUT samples there.
  task automatic model_edge();
    int  excl;
    int  w;
    bit  a;
    bit  l;
    if (slot_left == 2) begin
      slot_left = 1;
    end else begin
      if (slot_left == 1 && cur_num != 3'd0) exp_rf[cur_num] = cur_data;
      excl = (slot_left == 1) ? cur : -1;
      w = -1;
      if (pc_valid && excl != 0) begin
        w = 0;
      end else begin
        a = alu_valid && excl != 1;
        l = ld_valid && excl != 2;
        if (a && l) w = prefer_ld ? 2 : 1;
        else if (a) w = 1;
        else if (l) w = 2;
      end
      if (w >= 0) begin
        cur = w;
        case (w)
          0: begin cur_num = 3'd6;    cur_data = pc_data;  end
          1: begin cur_num = alu_num; cur_data = alu_data; prefer_ld = 1'b1; end
          default: begin cur_num = ld_num; cur_data = ld_data; prefer_ld = 1'b0; end
        endcase
        slot_left = 2;
      end else begin
        slot_left = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".en"},        rf_write_en, slot_left == 1);
    chk({tag, ".pc_ready"},  pc_ready,  slot_left == 1 && cur == 0);
    chk({tag, ".alu_ready"}, alu_ready, slot_left == 1 && cur == 1);
    chk({tag, ".ld_ready"},  ld_ready,  slot_left == 1 && cur == 2);
    chk({tag, ".pending"},   wr_pending, slot_left != 0);
    chk({tag, ".num"},       rf_write_num, cur_num);
    chk({tag, ".data"},      rf_write_data, cur_data);
    chk({tag, ".pend_num"},  wr_pending_num, cur_num);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive_from_reqs();
    pc_valid  = req_v[0];
    pc_data   = req_data[0];
    alu_valid = req_v[1];
    alu_num   = req_num[1];
    alu_data  = req_data[1];
    ld_valid  = req_v[2];
    ld_num    = req_num[2];
    ld_data   = req_data[2];
  endtask

  task automatic agents_update();
    for (int r = 0; r < 3; r++) begin
      if (done[r]) begin
        done[r] = 1'b0;
        if (r != 0 && $urandom_range(0, 1) == 1) begin
          req_num[r]  = 3'($urandom_range(0, 7));
          req_data[r] = 16'($urandom);
        end else begin
          req_v[r] = 1'b0;
        end
      end else if (req_v[r]) begin
        // Withdrawal is only legal while the request is not yet granted.
        if (r != 0 && !(slot_left != 0 && cur == r) && $urandom_range(0, 7) == 0)
          req_v[r] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req_v[r]    = 1'b1;
        req_num[r]  = (r == 0) ? 3'd6 : 3'($urandom_range(0, 7));
        req_data[r] = 16'($urandom);
      end
      if (slot_left == 1 && cur == r) done[r] = 1'b1;
    end
    drive_from_reqs();
  endtask

  logic [15:0] saved;

  initial begin
    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // PC, ALU and load valid together: PC, ALU, load, back to back.
    pc_valid = 1'b1; pc_data = 16'hC0DE;
    alu_valid = 1'b1; alu_num = 3'd4; alu_data = 16'h0A0A;
    ld_valid = 1'b1; ld_num = 3'd5; ld_data = 16'h0B0B;
    cycle("three.s1");
    chk("three.first_num", rf_write_num, 3'd6);
    cycle("three.c1");
    chk("three.pc_commit", pc_ready, 1'b1);
    pc_valid = 1'b0;
    cycle("three.s2");
    chk("three.second_num", rf_write_num, 3'd4);
    cycle("three.c2");
    chk("three.alu_commit", alu_ready, 1'b1);
    alu_valid = 1'b0;
    cycle("three.s3");
    chk("three.third_num", rf_write_num, 3'd5);
    cycle("three.c3");
    chk("three.ld_commit", ld_ready, 1'b1);
    ld_valid = 1'b0;
    cycle("three.idle");
    chk("three.r6", rf_mem[6], 16'hC0DE);
    chk("three.r5", rf_mem[5], 16'h0B0B);

    // Single ALU write r3 = 0x1234.
    alu_valid = 1'b1; alu_num = 3'd3; alu_data = 16'h1234;
    cycle("single.setup");
    chk("single.setup_en", rf_write_en, 1'b0);
    chk("single.setup_num", rf_write_num, 3'd3);
    cycle("single.commit");
    chk("single.commit_en", rf_write_en, 1'b1);
    alu_valid = 1'b0;
    cycle("single.after");
    chk("single.r3", rf_mem[3], 16'h1234);

    // ALU and load held valid: grants alternate.
    alu_valid = 1'b1; alu_num = 3'd1; alu_data = 16'h0011;
    ld_valid = 1'b1; ld_num = 3'd2; ld_data = 16'h0022;
    for (int i = 0; i < 8; i++) cycle("alt");
    alu_valid = 1'b0; ld_valid = 1'b0;
    cycle("alt.drain1");
    cycle("alt.drain2");
    chk("alt.r1", rf_mem[1], 16'h0011);
    chk("alt.r2", rf_mem[2], 16'h0022);

    // Load withdrawn while the ALU write commits.
    alu_valid = 1'b1; alu_num = 3'd3; alu_data = 16'h5555;
    cycle("wd.setup");
    ld_valid = 1'b1; ld_num = 3'd4; ld_data = 16'h7777;
    cycle("wd.commit");
    ld_valid = 1'b0;
    alu_valid = 1'b0;
    cycle("wd.idle");
    chk("wd.idle_pending", wr_pending, 1'b0);
    cycle("wd.idle2");
    chk("wd.no_ld_ready", ld_ready, 1'b0);
    chk("wd.r4", rf_mem[4], 16'h0A0A);

    // Reset during COMMIT aborts the write.
    saved = rf_mem[5];
    alu_valid = 1'b1; alu_num = 3'd5; alu_data = 16'hBEEF;
    cycle("rst.setup");
    cycle("rst.commit");
    #2 rst_n = 1'b0;
    #1;
    alu_valid = 1'b0;
    chk("rst.en_dropped", rf_write_en, 1'b0);
    chk("rst.ready_dropped", alu_ready, 1'b0);
    chk("rst.num_zero", rf_write_num, 3'd0);
    model_reset();
    check_outputs("rst.async");
    cycle("rst.held1");
    cycle("rst.held2");
    chk("rst.r5_unchanged", rf_mem[5], saved);
    @(negedge clk) rst_n = 1'b1;

    // Write to r0.
    alu_valid = 1'b1; alu_num = 3'd0; alu_data = 16'hFFFF;
    cycle("r0.setup");
    chk("r0.pend_num_setup", wr_pending_num, 3'd0);
    cycle("r0.commit");
    chk("r0.ready", alu_ready, 1'b1);
    chk("r0.pend_num_commit", wr_pending_num, 3'd0);
    alu_valid = 1'b0;
    cycle("r0.after");
    chk("r0.reads_zero", rf_mem[0], 16'h0);

    // Randomized traffic against the model.
    for (int r = 0; r < 3; r++) begin
      req_v[r] = 1'b0; req_num[r] = '0; req_data[r] = '0; done[r] = 1'b0;
    end
    for (int i = 0; i < 500; i++) begin
      cycle("rand");
      agents_update();
    end
    for (int r = 0; r < 3; r++) req_v[r] = 1'b0;
    drive_from_reqs();
    for (int i = 0; i < 4; i++) cycle("rand.drain");
    for (int k = 0; k < 8; k++) chk($sformatf("rand.rf%0d", k), rf_mem[k], exp_rf[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
